// File: rtl/mux_select_arbiter_pkg.sv
// Shared types and constants for the 16-way round-robin mux arbiter.
// Imported by the picker and the arbiter top.
package mux_select_arbiter_pkg;

  localparam int N_REQ        = 16;
  localparam int SEL_W        = 4;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_pick.sv
// Rotating-priority picker: first set req bit at or after base,
// wrapping 15->0.
module rr_pick_16
  import mux_select_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] base,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = base + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin owner of the shared 16:1 9-bit mux, with a per-grant
// beat limit and a valid/ready handshake toward the consumer.
module mux_select_arbiter
  import mux_select_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  input  logic             ready,
  output logic             sel3,
  output logic             sel2,
  output logic             sel1,
  output logic             sel0,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic             busy
);

  localparam logic [3:0] LIM = 4'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             any;
  logic [SEL_W-1:0] pick;
  logic             xfer;
  logic             rel;

  rr_pick_16 u_pick (
    .req  (req),
    .base (ptr_q),
    .any  (any),
    .idx  (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign xfer = valid && ready;
  assign rel  = (xfer && (last[owner_q] || cnt_q == LIM))
             || !req[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Withdrawal and last-beat both release once; ptr moves once.
        if (rel) begin
          state_d = IDLE;
          ptr_d   = owner_q + 4'd1;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == GRANT);
    valid = busy && req[owner_q];
    grant = busy ? onehot(owner_q) : '0;
  end

  // sel tracks the owner register, so it holds through IDLE.
  assign {sel3, sel2, sel1, sel0} = owner_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Randomized and directed bench for mux_select_arbiter against a
// transaction-level round-robin model.
module tb_mux_select_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] last = '0;
  logic        ready = 1'b0;
  logic        sel3, sel2, sel1, sel0;
  logic [15:0] grant;
  logic        valid, busy;

  int n_total = 0;
  int n_bad   = 0;

  // Model: owner index or -1 when idle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_sel   = 0;

  mux_select_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .last  (last),
    .ready (ready),
    .sel3  (sel3),
    .sel2  (sel2),
    .sel1  (sel1),
    .sel0  (sel0),
    .grant (grant),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eg;
    logic        ev;
    eg = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
    ev = (m_owner >= 0) && req[m_owner];
    chk({tag, ".grant"}, grant, eg);
    chk({tag, ".sel"}, {12'h0, sel3, sel2, sel1, sel0}, 16'(m_sel));
    chk({tag, ".valid"}, {15'h0, valid}, {15'h0, ev});
    chk({tag, ".busy"}, {15'h0, busy}, {15'h0, m_owner >= 0});
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask

  // Effect of the coming clock edge under the current inputs.
  task automatic model_edge();
    bit xfer;
    if (m_owner < 0) begin
      for (int i = 0; i < 16; i++) begin
        if (req[(m_ptr + i) % 16]) begin
          m_owner = (m_ptr + i) % 16;
          m_sel   = m_owner;
          m_cnt   = 0;
          break;
        end
      end
    end else begin
      xfer = req[m_owner] && ready;
      if (!req[m_owner] ||
          (xfer && (last[m_owner] || m_cnt + 1 == HOLD))) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
        m_cnt   = 0;
      end else if (xfer) begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [15:0] r, input logic [15:0] l,
                      input logic rd, input string tag);
    req   = r;
    last  = l;
    ready = rd;
    #3;
    check_model(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cur_sel();
    return {sel3, sel2, sel1, sel0};
  endfunction

  initial begin
    #12;
    chk("rst.grant", grant, 16'h0);
    chk("rst.busy", {15'h0, busy}, 16'h0);
    chk("rst.sel", {12'h0, cur_sel()}, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Single requester with last: one beat, then ptr = 4.
    step(16'h0008, 16'h0008, 1'b1, "single.idle");
    chk("single.sel", {12'h0, cur_sel()}, 16'h3);
    chk("single.grant", grant, 16'h0008);
    step(16'h0008, 16'h0008, 1'b1, "single.beat");
    chk("single.rel", {15'h0, busy}, 16'h0);
    step(16'h0009, 16'h0000, 1'b1, "wrap.idle");
    chk("wrap.sel", {12'h0, cur_sel()}, 16'h0);
    step(16'h0000, 16'h0000, 1'b1, "wrap.drop");
    step(16'h0000, 16'h0000, 1'b1, "wrap.rest");

    // Full round robin, one beat each.
    for (int i = 0; i < 40; i++)
      step(16'hFFFF, 16'hFFFF, 1'b1, "rr");
    step(16'h0000, 16'h0000, 1'b0, "rr.end");

    // Beat limit alternates 0 and 9.
    for (int i = 0; i < 24; i++)
      step(16'h0201, 16'h0000, 1'b1, "hold");
    step(16'h0000, 16'h0000, 1'b0, "hold.end");

    // Back-pressure on owner 5.
    step(16'h0020, 16'h0000, 1'b0, "bp.idle");
    chk("bp.grant", grant, 16'h0020);
    for (int i = 0; i < 5; i++)
      step(16'h0020, 16'h0000, 1'b0, "bp.hold");
    chk("bp.sel", {12'h0, cur_sel()}, 16'h5);
    step(16'h0020, 16'h0020, 1'b1, "bp.go");
    chk("bp.rel", {15'h0, busy}, 16'h0);

    // Withdrawal by owner 12, then wrap to 0.
    step(16'h1000, 16'h0000, 1'b0, "wd.idle");
    chk("wd.sel", {12'h0, cur_sel()}, 16'hC);
    step(16'h0000, 16'h0000, 1'b0, "wd.drop");
    step(16'h1001, 16'h0000, 1'b0, "wd.next");
    chk("wd.wrap", grant, 16'h0001);
    step(16'h0000, 16'h0000, 1'b0, "wd.end");
    step(16'h0000, 16'h0000, 1'b0, "wd.rest");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] r, l;
      r = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 16'($urandom);
      l = 16'($urandom) & 16'($urandom);
      step(r, l, ($urandom_range(0, 3) != 0), "rand");
    end

    // Async reset mid-grant, checked before the next edge.
    step(16'h0000, 16'h0000, 1'b0, "ar.pre");
    step(16'h0000, 16'h0000, 1'b0, "ar.pre2");
    step(16'h0040, 16'h0000, 1'b0, "ar.idle");
    chk("ar.busy_pre", {15'h0, busy}, 16'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.grant", grant, 16'h0);
    chk("ar.sel", {12'h0, cur_sel()}, 16'h0);
    chk("ar.valid", {15'h0, valid}, 16'h0);
    chk("ar.busy", {15'h0, busy}, 16'h0);
    req = 16'h0000;
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(16'h8001, 16'h0000, 1'b1, "ar.after");
    chk("ar.ptr0", grant, 16'h0001);
    step(16'h0000, 16'h0000, 1'b0, "ar.end");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
